adder_op_sequencer: RTL

Upstream operand sequencer for the registered 8-bit binary adder.
- Accepts a byte stream over a valid/ready handshake and assembles one operation: command, A, B.
- Drives the adder's EN, MODO, A, B and Cin inputs, waits a fixed adder latency, then captures Q and RCO.
- Returns the captured result over a valid/ready output handshake. One operation is in flight at a time.

---
 rtl/adder_op_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/adder_op_sequencer.sv
// Operand sequencer for the registered 8-bit adder: collects command/A/B bytes, issues one
// operation, waits ADDER_LAT cycles, then returns Q/RCO. Optional macro: SEQ_CHAIN_EN.
module adder_op_sequencer #(
  parameter int ADDER_LAT = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] IN_DATA,
  output logic       ADD_EN,
  output logic [1:0] ADD_MODO,
  output logic [7:0] ADD_A,
  output logic [7:0] ADD_B,
  output logic       ADD_CIN,
  input  logic [7:0] ADD_Q,
  input  logic       ADD_RCO,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] OUT_Q,
  output logic       OUT_RCO,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_CMD,
    S_GET_A,
    S_GET_B,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] lat_cnt;
  logic       alive;
  logic       chain_sel;

`ifdef SEQ_CHAIN_EN
  logic       chain;
  logic [3:0] unused_bits;
  assign chain_sel   = chain;
  assign unused_bits = IN_DATA[7:4];
`else
  logic [4:0] unused_bits;
  assign chain_sel   = 1'b0;
  assign unused_bits = IN_DATA[7:3];
`endif

  // alive keeps IN_READY low while reset is held and during the release cycle
  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    ADD_EN    = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b1;
    case (state)
      S_CMD: begin
        BUSY     = 1'b0;
        IN_READY = alive;
        if (IN_VALID && alive) state_nxt = S_GET_A;
      end
      S_GET_A: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_nxt = chain_sel ? S_ISSUE : S_GET_B;
      end
      S_GET_B: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        ADD_EN    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == 4'd0) state_nxt = S_OUT;
      end
      S_OUT: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_nxt = S_CMD;
      end
      default: begin
        BUSY      = 1'b0;
        state_nxt = S_CMD;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_CMD;
      alive    <= 1'b0;
      lat_cnt  <= 4'd0;
      ADD_MODO <= 2'd0;
      ADD_CIN  <= 1'b0;
      ADD_A    <= 8'd0;
      ADD_B    <= 8'd0;
      OUT_Q    <= 8'd0;
      OUT_RCO  <= 1'b0;
`ifdef SEQ_CHAIN_EN
      chain    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      case (state)
        S_CMD: begin
          if (IN_VALID && alive) begin
            ADD_MODO <= IN_DATA[1:0];
            ADD_CIN  <= IN_DATA[2];
`ifdef SEQ_CHAIN_EN
            chain    <= IN_DATA[3];
`endif
          end
        end
        S_GET_A: begin
          if (IN_VALID) begin
            ADD_A <= IN_DATA;
            // chained operations reuse the previous result as operand B
            if (chain_sel) ADD_B <= OUT_Q;
          end
        end
        S_GET_B: begin
          if (IN_VALID) ADD_B <= IN_DATA;
        end
        S_ISSUE: begin
          lat_cnt <= 4'(ADDER_LAT - 1);
        end
        S_WAIT: begin
          if (lat_cnt == 4'd0) begin
            OUT_Q   <= ADD_Q;
            OUT_RCO <= ADD_RCO;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
